hazard_track_unit: RTL and testbench

Pipeline hazard tracker and forwarding controller for the five-stage MIPS core. It consumes the D-stage Tuse/Tnew/A3 decode and the D-stage rs/rt fields. It carries shadow copies of A3, Tnew, rs and rt through E, M and W. From these it produces the D-stage stall and the forwarding mux selects for the D comparator, the E ALU operands and the M store data.

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/haz_stage_reg.sv | 45 ++++
 rtl/hazard_track_unit.sv | 85 ++++++++
 tb/tb_hazard_track_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the hazard tracker: Tnew latencies, forward
// codes, the per-stage tracking record and the match/select helpers.
package pipe_pkg;

    localparam int A3_W = 5;

    localparam logic [1:0] T_PC  = 2'd0;
    localparam logic [1:0] T_ALU = 2'd1;
    localparam logic [1:0] T_DM  = 2'd2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    typedef struct packed {
        logic [A3_W-1:0] a3;
        logic [1:0]      tnew;
        logic [A3_W-1:0] rs;
        logic [A3_W-1:0] rt;
    } haz_stage_t;

    // $0 is hard-wired, so a zero destination never produces a hazard.
    function automatic logic reg_match(input logic [A3_W-1:0] r, input logic [A3_W-1:0] a3);
        return (r != '0) && (r == a3);
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == T_PC) ? T_PC : t - 2'd1;
    endfunction

    // Nearest matching stage decides; if its value is not ready yet the
    // select stays at FWD_RF and the stall logic holds the consumer.
    function automatic logic [1:0] fwd_pick(input logic [A3_W-1:0] r,
                                            input logic use_e, input logic use_m,
                                            input haz_stage_t e, input haz_stage_t m,
                                            input haz_stage_t w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_e && reg_match(r, e.a3))
            sel = (e.tnew == T_PC) ? FWD_E : FWD_RF;
        else if (use_m && reg_match(r, m.a3))
            sel = (m.tnew == T_PC) ? FWD_M : FWD_RF;
        else if (reg_match(r, w.a3))
            sel = (w.tnew == T_PC) ? FWD_W : FWD_RF;
        return sel;
    endfunction

endpackage

// File: rtl/haz_stage_reg.sv
// One pipeline tracking stage (A3, Tnew, rs, rt) with bubble insertion and
// optional saturating Tnew decrement on capture.
module haz_stage_reg
    import pipe_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            bubble_i,
    input  logic            dec_i,
    input  logic [A3_W-1:0] a3_i,
    input  logic [1:0]      tnew_i,
    input  logic [A3_W-1:0] rs_i,
    input  logic [A3_W-1:0] rt_i,
    output logic [A3_W-1:0] a3_o,
    output logic [1:0]      tnew_o,
    output logic [A3_W-1:0] rs_o,
    output logic [A3_W-1:0] rt_o
);

    haz_stage_t stage_q, stage_d;

    always_comb begin
        stage_d.a3   = a3_i;
        stage_d.tnew = dec_i ? tnew_dec(tnew_i) : tnew_i;
        stage_d.rs   = rs_i;
        stage_d.rt   = rt_i;
        if (bubble_i) begin
            stage_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign a3_o   = stage_q.a3;
    assign tnew_o = stage_q.tnew;
    assign rs_o   = stage_q.rs;
    assign rt_o   = stage_q.rt;

endmodule

// File: rtl/hazard_track_unit.sv
// Hazard tracker / forwarding controller for the five-stage MIPS core.
// Define HAZ_FWD_EN for full forwarding; otherwise consumers wait for W.
module hazard_track_unit
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            Tuse_RS0,
    input  logic            Tuse_RS1,
    input  logic            Tuse_RT0,
    input  logic            Tuse_RT1,
    input  logic            Tuse_RT2,
    input  logic [1:0]      Tnew_D,
    input  logic [A3_W-1:0] A3_D,
    input  logic [A3_W-1:0] rs_D,
    input  logic [A3_W-1:0] rt_D,
    output logic            stall,
    output logic [1:0]      FwdRS_D,
    output logic [1:0]      FwdRT_D,
    output logic [1:0]      FwdRS_E,
    output logic [1:0]      FwdRT_E,
    output logic [1:0]      FwdRT_M
);

    haz_stage_t e_q, m_q, w_q;
    logic       stall_c;
    logic       unused_trk;

    haz_stage_reg u_stage_e (
        .clk_i(clk), .rst_i(reset), .bubble_i(stall_c), .dec_i(1'b0),
        .a3_i(A3_D), .tnew_i(Tnew_D), .rs_i(rs_D), .rt_i(rt_D),
        .a3_o(e_q.a3), .tnew_o(e_q.tnew), .rs_o(e_q.rs), .rt_o(e_q.rt)
    );

    haz_stage_reg u_stage_m (
        .clk_i(clk), .rst_i(reset), .bubble_i(1'b0), .dec_i(1'b1),
        .a3_i(e_q.a3), .tnew_i(e_q.tnew), .rs_i(e_q.rs), .rt_i(e_q.rt),
        .a3_o(m_q.a3), .tnew_o(m_q.tnew), .rs_o(m_q.rs), .rt_o(m_q.rt)
    );

    haz_stage_reg u_stage_w (
        .clk_i(clk), .rst_i(reset), .bubble_i(1'b0), .dec_i(1'b1),
        .a3_i(m_q.a3), .tnew_i(m_q.tnew), .rs_i(m_q.rs), .rt_i(m_q.rt),
        .a3_o(w_q.a3), .tnew_o(w_q.tnew), .rs_o(w_q.rs), .rt_o(w_q.rt)
    );

`ifdef HAZ_FWD_EN
    always_comb begin
        stall_c = (Tuse_RS0 && reg_match(rs_D, e_q.a3) && (e_q.tnew > T_PC))
               || (Tuse_RS0 && reg_match(rs_D, m_q.a3) && (m_q.tnew > T_PC))
               || (Tuse_RS1 && reg_match(rs_D, e_q.a3) && (e_q.tnew > T_ALU))
               || (Tuse_RT0 && reg_match(rt_D, e_q.a3) && (e_q.tnew > T_PC))
               || (Tuse_RT0 && reg_match(rt_D, m_q.a3) && (m_q.tnew > T_PC))
               || (Tuse_RT1 && reg_match(rt_D, e_q.a3) && (e_q.tnew > T_ALU));
    end

    always_comb begin
        FwdRS_D = fwd_pick(rs_D,   1'b1, 1'b1, e_q, m_q, w_q);
        FwdRT_D = fwd_pick(rt_D,   1'b1, 1'b1, e_q, m_q, w_q);
        FwdRS_E = fwd_pick(e_q.rs, 1'b0, 1'b1, e_q, m_q, w_q);
        FwdRT_E = fwd_pick(e_q.rt, 1'b0, 1'b1, e_q, m_q, w_q);
        FwdRT_M = fwd_pick(m_q.rt, 1'b0, 1'b0, e_q, m_q, w_q);
    end
`else
    // Without bypass paths any pending writer in E or M holds the reader in D.
    always_comb begin
        stall_c = ((Tuse_RS0 || Tuse_RS1)
                   && (reg_match(rs_D, e_q.a3) || reg_match(rs_D, m_q.a3)))
               || ((Tuse_RT0 || Tuse_RT1 || Tuse_RT2)
                   && (reg_match(rt_D, e_q.a3) || reg_match(rt_D, m_q.a3)));
    end

    always_comb begin
        FwdRS_D = FWD_RF;
        FwdRT_D = FWD_RF;
        FwdRS_E = FWD_RF;
        FwdRT_E = FWD_RF;
        FwdRT_M = FWD_RF;
    end
`endif

    assign stall      = stall_c;
    assign unused_trk = ^{e_q, m_q, w_q, Tuse_RT2};

endmodule

// File: tb/tb_hazard_track_unit.sv
// Directed bench for hazard_track_unit; expectations follow HAZ_FWD_EN.
module tb_hazard_track_unit;

    typedef struct packed {
        logic [4:0] tuse;   // {RS0, RS1, RT0, RT1, RT2}
        logic [1:0] tnew;
        logic [4:0] a3;
        logic [4:0] rs;
        logic [4:0] rt;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       stall;
        logic [1:0] rsd, rtd, rse, rte, rtm;
    } vec_t;

    localparam instr_t NOP   = '{tuse:5'b00000, tnew:2'd0, a3:5'd0,  rs:5'd0,  rt:5'd0};
    localparam instr_t LW5   = '{tuse:5'b01000, tnew:2'd2, a3:5'd5,  rs:5'd2,  rt:5'd5};
    localparam instr_t ADDU6 = '{tuse:5'b01010, tnew:2'd1, a3:5'd6,  rs:5'd5,  rt:5'd7};
    localparam instr_t BEQ6  = '{tuse:5'b10100, tnew:2'd0, a3:5'd0,  rs:5'd6,  rt:5'd0};
    localparam instr_t ADDU3 = '{tuse:5'b01010, tnew:2'd1, a3:5'd3,  rs:5'd1,  rt:5'd2};
    localparam instr_t BEQ3  = '{tuse:5'b10100, tnew:2'd0, a3:5'd0,  rs:5'd3,  rt:5'd0};
    localparam instr_t JAL   = '{tuse:5'b00000, tnew:2'd0, a3:5'd31, rs:5'd0,  rt:5'd0};
    localparam instr_t JR31  = '{tuse:5'b10000, tnew:2'd0, a3:5'd0,  rs:5'd31, rt:5'd0};
    localparam instr_t ORI4  = '{tuse:5'b01000, tnew:2'd1, a3:5'd4,  rs:5'd1,  rt:5'd4};
    localparam instr_t LUI4  = '{tuse:5'b00000, tnew:2'd1, a3:5'd4,  rs:5'd0,  rt:5'd4};
    localparam instr_t SW4   = '{tuse:5'b01001, tnew:2'd0, a3:5'd0,  rs:5'd2,  rt:5'd4};
    localparam instr_t ADDU0 = '{tuse:5'b01010, tnew:2'd1, a3:5'd0,  rs:5'd1,  rt:5'd2};
    localparam instr_t BEQ00 = '{tuse:5'b10100, tnew:2'd0, a3:5'd0,  rs:5'd0,  rt:5'd0};

    logic       clk = 1'b0;
    logic       reset;
    logic       Tuse_RS0, Tuse_RS1, Tuse_RT0, Tuse_RT1, Tuse_RT2;
    logic [1:0] Tnew_D;
    logic [4:0] A3_D, rs_D, rt_D;
    logic       stall;
    logic [1:0] FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E, FwdRT_M;

    int checks;
    int errors;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_track_unit dut (
        .clk(clk), .reset(reset),
        .Tuse_RS0(Tuse_RS0), .Tuse_RS1(Tuse_RS1),
        .Tuse_RT0(Tuse_RT0), .Tuse_RT1(Tuse_RT1), .Tuse_RT2(Tuse_RT2),
        .Tnew_D(Tnew_D), .A3_D(A3_D), .rs_D(rs_D), .rt_D(rt_D),
        .stall(stall),
        .FwdRS_D(FwdRS_D), .FwdRT_D(FwdRT_D),
        .FwdRS_E(FwdRS_E), .FwdRT_E(FwdRT_E), .FwdRT_M(FwdRT_M)
    );

    task automatic drive(input instr_t ins);
        {Tuse_RS0, Tuse_RS1, Tuse_RT0, Tuse_RT1, Tuse_RT2} = ins.tuse;
        Tnew_D = ins.tnew;
        A3_D   = ins.a3;
        rs_D   = ins.rs;
        rt_D   = ins.rt;
    endtask

    task automatic add(input instr_t ins, input logic st, input logic [1:0] rsd,
                       input logic [1:0] rtd, input logic [1:0] rse,
                       input logic [1:0] rte, input logic [1:0] rtm);
        vec_t v;
        v.ins = ins; v.stall = st;
        v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte; v.rtm = rtm;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int row, input logic st,
                           input logic [1:0] rsd, input logic [1:0] rtd,
                           input logic [1:0] rse, input logic [1:0] rte,
                           input logic [1:0] rtm);
        chk({tag, ".stall"},   row, int'(stall),   int'(st));
        chk({tag, ".FwdRS_D"}, row, int'(FwdRS_D), int'(rsd));
        chk({tag, ".FwdRT_D"}, row, int'(FwdRT_D), int'(rtd));
        chk({tag, ".FwdRS_E"}, row, int'(FwdRS_E), int'(rse));
        chk({tag, ".FwdRT_E"}, row, int'(FwdRT_E), int'(rte));
        chk({tag, ".FwdRT_M"}, row, int'(FwdRT_M), int'(rtm));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(ADDU6);
        #12;
        chk_all("in_reset", 0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef HAZ_FWD_EN
        add(LW5,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(ADDU6, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // load-use: one bubble
        add(ADDU6, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(NOP,   1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0);  // addu in E takes lw from W
        add(BEQ6,  1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
        add(ADDU3, 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        add(BEQ3,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // addu->beq: one stall
        add(BEQ3,  1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0);
        add(JAL,   1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0);
        add(JR31,  1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);  // jal ready in E
        add(ORI4,  1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0);
        add(LUI4,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(SW4,   1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0);  // RT2 never stalls
        add(NOP,   1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3);  // sw in E: M (lui) beats W (ori)
        add(NOP,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3);
        add(ADDU0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(BEQ00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // $0 never matches
        add(JAL,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(JAL,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(JR31,  1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);  // E and M both match: E wins
`else
        add(LW5,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(ADDU6, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(ADDU6, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(ADDU6, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(BEQ6,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(BEQ6,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(BEQ6,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(JAL,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(JR31,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // stalls despite Tnew=0
        add(JR31,  1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(JR31,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(LUI4,  1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(SW4,   1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);  // RT2 counts here
        add(SW4,   1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(SW4,   1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(ADDU0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        add(BEQ00, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
`endif

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ins);
            @(negedge clk);
            chk_all("vec", i, vecs[i].stall, vecs[i].rsd, vecs[i].rtd,
                    vecs[i].rse, vecs[i].rte, vecs[i].rtm);
            @(posedge clk);
            #1;
        end

        // lw $5 into E, dependent addu in D, then reset in the middle of the stall
        drive(LW5);
        @(posedge clk);
        #1;
        drive(ADDU6);
        @(negedge clk);
        chk("pre_reset.stall", 0, int'(stall), 1);
        reset = 1'b1;
        #1;
        chk_all("mid_reset", 0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("post_reset", 0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        drive(BEQ6);
        #1;
        chk("post_reset_beq.stall", 0, int'(stall), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
